inv_line_monitor: RTL and testbench
===================================

// Module: inv_line_monitor
// PURPOSE
//  Receiver side of a single-bit line driven by a CMOS inverter stage. Synchronises the
//  line into clk, rejects glitches shorter than STABLE_CYCLES, and emits one-cycle edge pulses.
//  Counts filtered edges and reports snapshots of that count over a valid/ready handshake.
//  Used as the digital observer for the switch-level inverter cells in this codebase.
// PARAMETERS
//  STABLE_CYCLES  4  consecutive synced cycles a new level must hold before acceptance (>=1)
//  CNT_W          8  width of edge counter and snapshot
// PORTS
//  clk         in   1      rising-edge clock
//  rst_n       in   1      asynchronous, active-low reset; one clock domain
//  line_in     in   1      asynchronous line from inverter output
//  clr         in   1      synchronous clear of edge count and pending report
//  filt_out    out  1      debounced level
//  rise_pulse  out  1      1-cycle pulse on accepted 0->1
//  fall_pulse  out  1      1-cycle pulse on accepted 1->0
//  edge_cnt    out  CNT_W  live count of accepted edges, saturating
//  cnt_valid   out  1      snapshot available
//  cnt_ready   in   1      consumer accepts snapshot
//  cnt_data    out  CNT_W  snapshot, stable while cnt_valid=1
//  glitch_cnt  out  CNT_W  rejected-glitch count (only with GLITCH_CNT_EN)
// BEHAVIOUR
//  - Reset (async assert, sync release): sync flops, filt_out, pulses, edge_cnt, cnt_valid,
//    cnt_data, debounce counter, pending flag, glitch_cnt all 0; FSM in IDLE.
//  - Sync: 2-FF chain line_in -> s1 -> s2; only s2 used downstream.
//  - Debounce: dcnt counts cycles with s2 != filt_out. When s2 != filt_out and
//    dcnt == STABLE_CYCLES-1, filt_out <= s2, dcnt <= 0, matching edge pulse asserted that
//    same cycle (registered, coincident with filt_out change). If s2 == filt_out, dcnt <= 0.
//  - Latency: line_in step to filt_out change = 2 + STABLE_CYCLES clocks.
//  - Glitch: s2 returning to filt_out with dcnt != 0 is a rejected glitch.
//  - edge_cnt += 1 per accepted edge; saturates at 2^CNT_W-1 (no wrap).
//  - FSM IDLE: on accepted edge -> REPORT, cnt_data <= incremented edge_cnt, cnt_valid <= 1.
//  - FSM REPORT: cnt_data held. Edges still update edge_cnt and set pending.
//    On cnt_valid & cnt_ready: if pending (or edge this cycle) reload cnt_data with current
//    count, clear pending, stay REPORT; else cnt_valid <= 0, -> IDLE.
//  - cnt_valid never drops without handshake (except clr/reset).
//  - clr: edge_cnt, pending <= 0; cnt_valid <= 0, FSM -> IDLE. clr wins over a same-cycle
//    edge (count stays 0, no report); filt_out and pulses unaffected.
//  - Reset mid-debounce or mid-report: everything returns to reset values; line must
//    re-qualify from 0 (a high line yields a rise after 2+STABLE_CYCLES clocks).
// CONFIGURATION
//  GLITCH_CNT_EN defined: glitch_cnt port present; +1 per rejected glitch, saturating,
//    cleared by rst_n and clr.
//  GLITCH_CNT_EN undefined: glitch_cnt port and logic absent; all else identical.
// TESTING (STABLE_CYCLES=4, CNT_W=8)
//  1 reset release, line_in=1 held -> filt_out=1 and rise_pulse on clock 6; cnt_valid=1,
//    cnt_data=1.
//  2 line_in 0->1 held 3 clocks then 0 -> no edge, edge_cnt unchanged, glitch_cnt +1
//    (with GLITCH_CNT_EN).
//  3 cnt_ready=0, three accepted edges -> cnt_data stays 1, edge_cnt=3; raise cnt_ready ->
//    handshake, cnt_data=3 next cycle, valid held; second handshake -> cnt_valid=0.
//  4 260 accepted edges -> edge_cnt saturates at 255, no wrap.
//  5 clr same cycle as accepted edge in IDLE -> edge_cnt=0, cnt_valid stays 0, pulse still seen.
//  6 rst_n low mid-REPORT with dcnt=2 -> all outputs 0 asynchronously, FSM IDLE after release.

Source files
------------

// File: rtl/inv_line_monitor.sv
`default_nettype none
// ============================================================================
// Module      : inv_line_monitor
// Description : Receiver for a single-bit line driven by an inverter stage.
//               Two-flop synchroniser, glitch-rejecting debounce filter,
//               one-cycle edge pulses, a saturating edge counter and a
//               valid/ready snapshot port for the count.
//               Optional feature macro: GLITCH_CNT_EN (adds glitch_cnt port).
// Revision    : 1.0 - initial release
// ============================================================================
module inv_line_monitor #(
  parameter int STABLE_CYCLES = 4,
  parameter int CNT_W         = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             line_in,
  input  logic             clr,
  input  logic             cnt_ready,
  output logic             filt_out,
  output logic             rise_pulse,
  output logic             fall_pulse,
  output logic [CNT_W-1:0] edge_cnt,
  output logic             cnt_valid,
  output logic [CNT_W-1:0] cnt_data
`ifdef GLITCH_CNT_EN
  ,
  output logic [CNT_W-1:0] glitch_cnt
`endif
);

  // Debounce counter only needs to reach STABLE_CYCLES-1; keep at least 1 bit.
  localparam int DCNT_W = (STABLE_CYCLES > 1) ? $clog2(STABLE_CYCLES) : 1;
  localparam logic [DCNT_W-1:0] C_DCNT_LAST = DCNT_W'(STABLE_CYCLES - 1);
  localparam logic [CNT_W-1:0]  C_CNT_MAX   = '1;

  typedef enum logic [0:0] {
    ST_IDLE   = 1'b0,
    ST_REPORT = 1'b1
  } state_t;

  logic              r_s1;
  logic              r_s2;
  logic [DCNT_W-1:0] r_dcnt;
  logic              r_pending;
  state_t            r_state;

  logic              w_differs;
  logic              w_accept;
  logic [CNT_W-1:0]  w_cnt_next;
  state_t            w_state_next;
  logic              w_valid_next;
  logic [CNT_W-1:0]  w_data_next;
  logic              w_pending_next;

  // A new level is accepted on the cycle it has already differed for
  // STABLE_CYCLES-1 cycles, so filt_out moves on the STABLE_CYCLES-th cycle.
  assign w_differs  = (r_s2 != filt_out);
  assign w_accept   = w_differs && (r_dcnt == C_DCNT_LAST);
  assign w_cnt_next = (w_accept && (edge_cnt != C_CNT_MAX)) ? edge_cnt + 1'b1 : edge_cnt;

  // Two-flop synchroniser for the asynchronous line.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_s1 <= 1'b0;
      r_s2 <= 1'b0;
    end else begin
      r_s1 <= line_in;
      r_s2 <= r_s1;
    end
  end

  // Debounce filter with registered edge pulses coincident with filt_out.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_dcnt     <= '0;
      filt_out   <= 1'b0;
      rise_pulse <= 1'b0;
      fall_pulse <= 1'b0;
    end else begin
      rise_pulse <= w_accept && r_s2;
      fall_pulse <= w_accept && !r_s2;
      if (w_accept) begin
        filt_out <= r_s2;
        r_dcnt   <= '0;
      end else if (w_differs) begin
        r_dcnt   <= r_dcnt + 1'b1;
      end else begin
        r_dcnt   <= '0;
      end
    end
  end

  // Report FSM: decides when to load a snapshot and when valid may drop.
  always_comb begin
    w_state_next   = r_state;
    w_valid_next   = cnt_valid;
    w_data_next    = cnt_data;
    w_pending_next = r_pending;
    if (clr) begin
      w_state_next   = ST_IDLE;
      w_valid_next   = 1'b0;
      w_pending_next = 1'b0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (w_accept) begin
            w_state_next = ST_REPORT;
            w_valid_next = 1'b1;
            w_data_next  = w_cnt_next;
          end
        end
        ST_REPORT: begin
          if (cnt_valid && cnt_ready) begin
            // Count moved since the snapshot was taken: publish the newer value.
            if (r_pending || w_accept) begin
              w_data_next    = w_cnt_next;
              w_pending_next = 1'b0;
            end else begin
              w_valid_next = 1'b0;
              w_state_next = ST_IDLE;
            end
          end else if (w_accept) begin
            w_pending_next = 1'b1;
          end
        end
        default: begin
          w_state_next = ST_IDLE;
          w_valid_next = 1'b0;
        end
      endcase
    end
  end

  // Report state, snapshot and live edge counter registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state   <= ST_IDLE;
      cnt_valid <= 1'b0;
      cnt_data  <= '0;
      r_pending <= 1'b0;
      edge_cnt  <= '0;
    end else begin
      r_state   <= w_state_next;
      cnt_valid <= w_valid_next;
      cnt_data  <= w_data_next;
      r_pending <= w_pending_next;
      edge_cnt  <= clr ? '0 : w_cnt_next;
    end
  end

`ifdef GLITCH_CNT_EN
  logic w_glitch;

  // The synced line fell back to the filtered level before qualifying.
  assign w_glitch = !w_differs && (r_dcnt != '0);

  // Saturating count of rejected glitches.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      glitch_cnt <= '0;
    end else if (clr) begin
      glitch_cnt <= '0;
    end else if (w_glitch && (glitch_cnt != C_CNT_MAX)) begin
      glitch_cnt <= glitch_cnt + 1'b1;
    end
  end
`endif

endmodule
`default_nettype wire

// File: tb/tb_inv_line_monitor.sv
`default_nettype none
// ============================================================================
// Module      : tb_inv_line_monitor
// Description : Directed self-checking bench for inv_line_monitor
//               (STABLE_CYCLES=4, CNT_W=8). Glitch counter checks are
//               compiled in when GLITCH_CNT_EN is defined.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_inv_line_monitor;

  logic       clk;
  logic       rst_n;
  logic       line_in;
  logic       clr;
  logic       cnt_ready;
  logic       filt_out;
  logic       rise_pulse;
  logic       fall_pulse;
  logic [7:0] edge_cnt;
  logic       cnt_valid;
  logic [7:0] cnt_data;
`ifdef GLITCH_CNT_EN
  logic [7:0] glitch_cnt;
`endif

  int checks = 0;
  int errors = 0;

  inv_line_monitor #(
    .STABLE_CYCLES(4),
    .CNT_W        (8)
  ) u_dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .line_in   (line_in),
    .clr       (clr),
    .cnt_ready (cnt_ready),
    .filt_out  (filt_out),
    .rise_pulse(rise_pulse),
    .fall_pulse(fall_pulse),
    .edge_cnt  (edge_cnt),
    .cnt_valid (cnt_valid),
    .cnt_data  (cnt_data)
`ifdef GLITCH_CNT_EN
    ,
    .glitch_cnt(glitch_cnt)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Single comparison point for the whole bench.
  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0d expected=%0d", tag, got, exp);
    end
  endtask

  // Advance n rising edges; outputs are then sampled 1 ns after the edge.
  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    tick(2);
    rst_n = 1'b1;
  endtask

  // Drive a new level and hold it until it has just been accepted (2+4 clocks).
  task automatic set_line(input logic v);
    line_in = v;
    tick(6);
  endtask

  initial begin
    rst_n     = 1'b0;
    line_in   = 1'b1;
    clr       = 1'b0;
    cnt_ready = 1'b0;

    // 1: high line out of reset qualifies on the 6th clock.
    do_reset();
    check("reset_filt", 32'(filt_out), 0);
    check("reset_valid", 32'(cnt_valid), 0);
    check("reset_edge_cnt", 32'(edge_cnt), 0);
    tick(5);
    check("pre_accept_filt", 32'(filt_out), 0);
    check("pre_accept_rise", 32'(rise_pulse), 0);
    tick(1);
    check("accept_filt", 32'(filt_out), 1);
    check("accept_rise", 32'(rise_pulse), 1);
    check("accept_valid", 32'(cnt_valid), 1);
    check("accept_data", 32'(cnt_data), 1);
    tick(1);
    check("rise_one_cycle", 32'(rise_pulse), 0);

    // 2: a 3-clock high pulse is rejected.
    line_in = 1'b0;
    do_reset();
    tick(2);
    line_in = 1'b1;
    tick(3);
    line_in = 1'b0;
    tick(8);
    check("glitch_filt", 32'(filt_out), 0);
    check("glitch_edge_cnt", 32'(edge_cnt), 0);
    check("glitch_valid", 32'(cnt_valid), 0);
`ifdef GLITCH_CNT_EN
    check("glitch_cnt", 32'(glitch_cnt), 1);
`endif

    // 3: three edges with consumer stalled, then two handshakes.
    do_reset();
    set_line(1'b1);
    set_line(1'b0);
    check("fall_pulse", 32'(fall_pulse), 1);
    check("stall_valid_mid", 32'(cnt_valid), 1);
    set_line(1'b1);
    check("stall_edge_cnt", 32'(edge_cnt), 3);
    check("stall_data", 32'(cnt_data), 1);
    cnt_ready = 1'b1;
    tick(1);
    check("hs1_valid", 32'(cnt_valid), 1);
    check("hs1_data", 32'(cnt_data), 3);
    tick(1);
    check("hs2_valid", 32'(cnt_valid), 0);
    cnt_ready = 1'b0;

    // 4: 260 edges saturate the counter at 255.
    line_in = 1'b0;
    do_reset();
    cnt_ready = 1'b1;
    for (int i = 0; i < 260; i++) begin
      set_line((i % 2) == 0);
      if (i == 254) check("sat_reach_255", 32'(edge_cnt), 255);
    end
    tick(2);
    check("sat_edge_cnt", 32'(edge_cnt), 255);
    check("sat_data", 32'(cnt_data), 255);
    check("sat_valid_done", 32'(cnt_valid), 0);
    cnt_ready = 1'b0;

    // 5: clr coincident with an accepted edge in IDLE.
    line_in = 1'b0;
    do_reset();
    line_in = 1'b1;
    tick(5);
    clr = 1'b1;
    tick(1);
    clr = 1'b0;
    check("clr_rise", 32'(rise_pulse), 1);
    check("clr_filt", 32'(filt_out), 1);
    check("clr_edge_cnt", 32'(edge_cnt), 0);
    check("clr_valid", 32'(cnt_valid), 0);
    tick(2);
    check("clr_valid_later", 32'(cnt_valid), 0);

    // 6: asynchronous reset in REPORT while a falling level is half qualified.
    line_in = 1'b0;
    do_reset();
    set_line(1'b1);
    line_in = 1'b0;
    tick(4);
    check("mid_filt_held", 32'(filt_out), 1);
    #2;
    rst_n = 1'b0;
    #1;
    check("async_filt", 32'(filt_out), 0);
    check("async_valid", 32'(cnt_valid), 0);
    check("async_edge_cnt", 32'(edge_cnt), 0);
    check("async_data", 32'(cnt_data), 0);
    tick(1);
    rst_n = 1'b1;
    tick(8);
    check("post_reset_filt", 32'(filt_out), 0);
    check("post_reset_valid", 32'(cnt_valid), 0);
    set_line(1'b1);
    check("requal_rise", 32'(rise_pulse), 1);
    check("requal_data", 32'(cnt_data), 1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
